// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the oversampling UART receiver.
// Optional build macro used by this slice: RX_MAJORITY_EN (2-of-3 bit voting).
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam int unsigned PRESCALE_8  = 8;
  localparam int unsigned PRESCALE_16 = 16;
  localparam int unsigned PRESCALE_32 = 32;

  // Parity_type encoding, shared with the transmitter.
  localparam logic PARITY_ODD = 1'b1;

  function automatic logic expected_parity(input logic data_xor, input logic parity_type);
    return (parity_type == PARITY_ODD) ? ~data_xor : data_xor;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Bit timing for uart_rx: edge counter, bit counter and bit-value sampling.
// With RX_MAJORITY_EN defined, bits are voted 2-of-3 and strobed one cycle later.
module uart_rx_sampler #(
  parameter int unsigned PRESCALE_W = 6,
  parameter int unsigned BIT_W      = 3
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  run,
  input  logic                  count_bits,
  input  logic                  rx_s,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  sample_stb,
  output logic                  sample_bit,
  output logic                  bit_end,
  output logic [BIT_W-1:0]      bit_cnt
);

  logic [PRESCALE_W-1:0] edge_cnt;
  logic [PRESCALE_W-1:0] half;
  logic [PRESCALE_W-1:0] last;

  assign half    = prescale >> 1;
  assign last    = prescale - PRESCALE_W'(1);
  assign bit_end = run && (edge_cnt == last);

  always_ff @(posedge CLK) begin
    if (!Reset || !run) begin
      edge_cnt <= '0;
    end else if (edge_cnt == last) begin
      edge_cnt <= '0;
    end else begin
      edge_cnt <= edge_cnt + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!Reset || !count_bits) begin
      bit_cnt <= '0;
    end else if (bit_end) begin
      bit_cnt <= bit_cnt + BIT_W'(1);
    end
  end

`ifdef RX_MAJORITY_EN
  // Early samples at P/2-1 and P/2; the third vote is the live value at P/2+1.
  logic [1:0] early;

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      early <= 2'b11;
    end else begin
      if (edge_cnt == half - PRESCALE_W'(1)) early[0] <= rx_s;
      if (edge_cnt == half)                  early[1] <= rx_s;
    end
  end

  assign sample_stb = run && (edge_cnt == half + PRESCALE_W'(1));
  assign sample_bit = (early[0] & early[1]) | (early[0] & rx_s) | (early[1] & rx_s);
`else
  assign sample_stb = run && (edge_cnt == half);
  assign sample_bit = rx_s;
`endif

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start, width data bits LSB first, optional parity, one stop.
// Build macro RX_MAJORITY_EN selects 2-of-3 majority sampling of each bit.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned width      = 8,
  parameter int unsigned PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  Rx_in,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  Parity_EN,
  input  logic                  Parity_type,
  output logic [width-1:0]      Data,
  output logic                  Data_valid,
  output logic                  Parity_error,
  output logic                  Stop_error,
  output logic                  Busy
);

  localparam int unsigned BIT_W = (width > 1) ? $clog2(width) : 1;

  rx_state_e             state;
  logic                  rx_meta;
  logic                  rx_s;
  logic [PRESCALE_W-1:0] presc_q;
  logic                  par_en_q;
  logic                  par_type_q;
  logic                  par_err_q;
  logic [width-1:0]      shreg;
  logic                  sample_stb;
  logic                  sample_bit;
  logic                  bit_end;
  logic [BIT_W-1:0]      bit_cnt;

  // Two-flop synchronizer; idle-high line so reset loads 1.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= Rx_in;
      rx_s    <= rx_meta;
    end
  end

  uart_rx_sampler #(
    .PRESCALE_W(PRESCALE_W),
    .BIT_W     (BIT_W)
  ) u_sampler (
    .CLK       (CLK),
    .Reset     (Reset),
    .run       (state != IDLE),
    .count_bits(state == DATA),
    .rx_s      (rx_s),
    .prescale  (presc_q),
    .sample_stb(sample_stb),
    .sample_bit(sample_bit),
    .bit_end   (bit_end),
    .bit_cnt   (bit_cnt)
  );

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state        <= IDLE;
      presc_q      <= '0;
      par_en_q     <= 1'b0;
      par_type_q   <= 1'b0;
      par_err_q    <= 1'b0;
      shreg        <= '0;
      Data         <= '0;
      Data_valid   <= 1'b0;
      Parity_error <= 1'b0;
      Stop_error   <= 1'b0;
      Busy         <= 1'b0;
    end else begin
      Data_valid   <= 1'b0;
      Parity_error <= 1'b0;
      Stop_error   <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state      <= START;
            Busy       <= 1'b1;
            presc_q    <= Prescale;
            par_en_q   <= Parity_EN;
            par_type_q <= Parity_type;
            par_err_q  <= 1'b0;
          end
        end
        START: begin
          // A high line at the sample point means the falling edge was noise.
          if (sample_stb && sample_bit) begin
            state <= IDLE;
            Busy  <= 1'b0;
          end else if (bit_end) begin
            state <= DATA;
          end
        end
        DATA: begin
          if (sample_stb) shreg <= {sample_bit, shreg[width-1:1]};
          if (bit_end && (bit_cnt == BIT_W'(width - 1))) begin
            state <= par_en_q ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (sample_stb) par_err_q <= (sample_bit != expected_parity(^shreg, par_type_q));
          if (bit_end) state <= STOP;
        end
        STOP: begin
          // Leave at mid-stop so a back-to-back start edge is not missed.
          if (sample_stb) begin
            state        <= IDLE;
            Busy         <= 1'b0;
            Parity_error <= par_err_q;
            Stop_error   <= ~sample_bit;
            if (!par_err_q && sample_bit) begin
              Data       <= shreg;
              Data_valid <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: vector table of frames plus hand-built corner sequences.
module tb_uart_rx;
  import uart_rx_pkg::*;

  localparam int unsigned W  = 8;
  localparam int unsigned PW = 6;

  logic          CLK = 1'b0;
  logic          Reset;
  logic          Rx_in;
  logic [PW-1:0] Prescale;
  logic          Parity_EN;
  logic          Parity_type;
  logic [W-1:0]  Data;
  logic          Data_valid;
  logic          Parity_error;
  logic          Stop_error;
  logic          Busy;

  uart_rx #(.width(W), .PRESCALE_W(PW)) dut (
    .CLK         (CLK),
    .Reset       (Reset),
    .Rx_in       (Rx_in),
    .Prescale    (Prescale),
    .Parity_EN   (Parity_EN),
    .Parity_type (Parity_type),
    .Data        (Data),
    .Data_valid  (Data_valid),
    .Parity_error(Parity_error),
    .Stop_error  (Stop_error),
    .Busy        (Busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] data;
    logic       valid;
    logic       perr;
    logic       serr;
  } exp_t;

  typedef struct {
    int         p;
    logic       pen;
    logic       ptype;
    logic [7:0] data;
    logic       par_bad;
    logic       stop;
    logic       exp_valid;
    logic       exp_perr;
    logic       exp_serr;
  } vec_t;

  localparam int NV = 8;

  exp_t       exp_q[$];
  vec_t       vecs[NV];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] last_good;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Every flag cycle consumes one expectation; a stray or stretched pulse finds none.
  always @(negedge CLK) begin
    exp_t e;
    if (Reset === 1'b1 && (Data_valid || Parity_error || Stop_error)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_flags", 32'({Data_valid, Parity_error, Stop_error}), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("data_valid", 32'(Data_valid), 32'(e.valid));
        check("parity_error", 32'(Parity_error), 32'(e.perr));
        check("stop_error", 32'(Stop_error), 32'(e.serr));
        check("data", 32'(Data), 32'(e.data));
        check("busy_at_flags", 32'(Busy), 32'd0);
      end
    end
  end

  task automatic expect_frame(input logic [7:0] d, input logic v, input logic pe, input logic se);
    exp_t e;
    if (v) last_good = d;
    e.data  = last_good;
    e.valid = v;
    e.perr  = pe;
    e.serr  = se;
    exp_q.push_back(e);
  endtask

  task automatic drive_bit(input logic b, input int p);
    Rx_in = b;
    repeat (p) @(posedge CLK);
    #1;
  endtask

  // Inverts the line for one cycle at the point a single-sample receiver would use.
  task automatic spike_bit(input logic b, input int p);
    Rx_in = b;
    repeat (p / 2 + 1) @(posedge CLK);
    #1 Rx_in = ~b;
    @(posedge CLK);
    #1 Rx_in = b;
    repeat (p - p / 2 - 2) @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    Rx_in = 1'b1;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_frame(input int p, input logic pen, input logic ptype, input logic [7:0] d,
                            input logic par_bad, input logic stop);
    logic pbit;
    Prescale    = PW'(p);
    Parity_EN   = pen;
    Parity_type = ptype;
    // Odd parity: total ones (data + parity) odd; even: total even.
    if (ptype) pbit = ($countones(d) % 2 == 0);
    else       pbit = ($countones(d) % 2 == 1);
    drive_bit(1'b0, p);
    for (int i = 0; i < 8; i++) drive_bit(d[i], p);
    if (pen) drive_bit(pbit ^ par_bad, p);
    drive_bit(stop, p);
  endtask

  task automatic drain(input string name);
    check(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    check({name, "_busy"}, 32'(Busy), 32'd0);
    check({name, "_data"}, 32'(Data), 32'(last_good));
  endtask

  initial begin
    Reset       = 1'b0;
    Rx_in       = 1'b1;
    Prescale    = PW'(PRESCALE_8);
    Parity_EN   = 1'b0;
    Parity_type = 1'b0;
    last_good   = 8'h00;

    //           p            pen   ptype data   pbad  stop  valid perr  serr
    vecs[0] = '{PRESCALE_8,  1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{PRESCALE_16, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{PRESCALE_16, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{PRESCALE_32, 1'b0, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{PRESCALE_16, 1'b1, 1'b0, 8'h5B, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{PRESCALE_8,  1'b1, 1'b0, 8'h81, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{PRESCALE_32, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{PRESCALE_8,  1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    repeat (3) @(posedge CLK);
    #1;
    check("rst_data", 32'(Data), 32'd0);
    check("rst_valid", 32'(Data_valid), 32'd0);
    check("rst_perr", 32'(Parity_error), 32'd0);
    check("rst_serr", 32'(Stop_error), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    Reset = 1'b1;
    idle(5);

    for (int i = 0; i < NV; i++) begin
      expect_frame(vecs[i].data, vecs[i].exp_valid, vecs[i].exp_perr, vecs[i].exp_serr);
      send_frame(vecs[i].p, vecs[i].pen, vecs[i].ptype, vecs[i].data, vecs[i].par_bad, vecs[i].stop);
      idle(3 * vecs[i].p);
      drain($sformatf("vec%0d", i));
    end

    // Short low glitch: start rejected, nothing reported, next frame clean.
    Prescale  = PW'(PRESCALE_16);
    Parity_EN = 1'b0;
    Rx_in     = 1'b0;
    repeat (3) @(posedge CLK);
    #1 Rx_in = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check("glitch_busy_high", 32'(Busy), 32'd1);
    idle(40);
    drain("glitch");
    expect_frame(8'h55, 1'b1, 1'b0, 1'b0);
    send_frame(PRESCALE_16, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1);
    idle(48);
    drain("after_glitch");

    // Back-to-back frames, no idle gap between stop and next start.
    expect_frame(8'h01, 1'b1, 1'b0, 1'b0);
    send_frame(PRESCALE_8, 1'b0, 1'b0, 8'h01, 1'b0, 1'b1);
    expect_frame(8'hFF, 1'b1, 1'b0, 1'b0);
    send_frame(PRESCALE_8, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1);
    idle(30);
    drain("b2b");

    // Reset pulse in the middle of the data bits of 0x81.
    Prescale = PW'(PRESCALE_16);
    drive_bit(1'b0, 16);
    drive_bit(1'b1, 16);
    drive_bit(1'b0, 16);
    drive_bit(1'b0, 16);
    Rx_in = 1'b1;
    Reset = 1'b0;
    @(posedge CLK);
    #1 Reset = 1'b1;
    check("midrst_data", 32'(Data), 32'd0);
    check("midrst_valid", 32'(Data_valid), 32'd0);
    check("midrst_perr", 32'(Parity_error), 32'd0);
    check("midrst_serr", 32'(Stop_error), 32'd0);
    check("midrst_busy", 32'(Busy), 32'd0);
    last_good = 8'h00;
    idle(200);
    drain("midrst_idle");
    expect_frame(8'h42, 1'b1, 1'b0, 1'b0);
    send_frame(PRESCALE_16, 1'b0, 1'b0, 8'h42, 1'b0, 1'b1);
    idle(48);
    drain("after_rst");

`ifdef RX_MAJORITY_EN
    // One-cycle inverted spike inside data bit 2 must be outvoted.
    begin
      logic [7:0] d;
      d           = 8'hA5;
      Prescale    = PW'(PRESCALE_16);
      Parity_EN   = 1'b0;
      Parity_type = 1'b0;
      expect_frame(d, 1'b1, 1'b0, 1'b0);
      drive_bit(1'b0, 16);
      for (int i = 0; i < 8; i++) begin
        if (i == 2) spike_bit(d[i], 16);
        else        drive_bit(d[i], 16);
      end
      drive_bit(1'b1, 16);
      idle(48);
      drain("majority_spike");
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Oversampling UART receiver; the far end of the existing UART transmit path.
- Recovers frames from the serial line: start bit, `width` data bits LSB first, optional parity bit, one stop bit.
- Presents the parallel word with a one-cycle valid pulse, plus parity and framing error flags.
- Sits between the pad-side Rx line and the system register/control logic, on the same CLK as the transmitter.

Parameters:
- width, 8, number of data bits per frame.
- PRESCALE_W, 6, width of the Prescale port.

Ports:
- CLK  input  1  system clock; all logic on posedge.
- Reset  input  1  synchronous, active-low reset.
- Rx_in  input  1  asynchronous serial line; idles high.
- Prescale  input  PRESCALE_W  CLK cycles per bit; legal values 8, 16, 32.
- Parity_EN  input  1  1 = a parity bit follows the data bits.
- Parity_type  input  1  1 = odd parity, 0 = even parity. Same encoding as the transmitter.
- Data  output  width  last received word; holds until the next good frame.
- Data_valid  output  1  one-cycle pulse for an error-free frame.
- Parity_error  output  1  one-cycle pulse when the parity bit mismatches.
- Stop_error  output  1  one-cycle pulse when the stop bit is sampled low.
- Busy  output  1  high from start detect until the return to IDLE.

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-low: when Reset=0 at a CLK posedge, the following take their reset values:
  - All outputs go to 0.
  - FSM goes to IDLE.
  - Counters clear.
  - Synchronizer flops load 1.
- Reset mid-frame: the frame is abandoned and no flag pulses.
- Input synchronizer: Rx_in passes through a 2-flop synchronizer; all sampling uses the synchronized value rx_s.
- Prescale latch: Prescale, Parity_EN and Parity_type are latched on leaving IDLE. Changes mid-frame take effect on the next frame.
- Edge counter: counts 0..P-1 per bit, where P is the latched Prescale.
  - The sample point is edge_cnt == P/2.
  - At edge_cnt == P-1 the counter wraps to 0 and the bit counter advances.
- States and transitions:
  - IDLE: rx_s==0 -> START, with edge_cnt cleared and Busy set.
  - START: at the sample point, a sample of 1 is a glitch -> IDLE with no flags. At end of bit -> DATA.
  - DATA: sample bit_cnt 0..width-1, shifted in LSB first. After the last bit -> PARITY if Parity_EN, else STOP.
  - PARITY: sample the received bit and compare against the expected value.
    - Expected = ~^data when Parity_type=1; ^data when Parity_type=0.
    - Store the mismatch. At end of bit -> STOP.
  - STOP: at the sample point, evaluate the frame and go to IDLE immediately. The remaining half bit is not waited out, so back-to-back frames are accepted.
- Stop-point evaluation, registered the next cycle:
  - No errors: Data loads the shift register and Data_valid=1 for exactly one cycle.
  - Parity mismatch: Parity_error=1; Data is not updated.
  - Stop sampled 0: Stop_error=1; Data is not updated.
  - Both errors: both flags pulse.
- Busy falls in the same cycle the flags pulse.
- Latency: Data_valid rises P/2+1 cycles into the stop bit, counted from the synchronized edge.
- Line held low: produces repeated frames of data 0 with Stop_error, one per frame length. No lock-up.
- Sample value: a single sample at P/2, unless RX_MAJORITY_EN is defined.

Optional Feature:
- Macro: RX_MAJORITY_EN.
- Defined: each bit value is the 2-of-3 majority of samples at P/2-1, P/2 and P/2+1. The decision is taken at P/2+1, and all per-bit actions shift one cycle later accordingly.
- Undefined: single sample at P/2. No extra flops are built.

Decomposition:
- Package uart_rx_pkg holds:
  - state enum IDLE/START/DATA/PARITY/STOP;
  - legal prescale constants 8/16/32;
  - the parity encoding constant (1 = odd).
- Sub-module uart_rx_sampler holds the edge counter, the bit counter and the sample/majority logic. It outputs sample_stb, sample_bit and bit_end to the FSM.

Test Plan:
- Prescale=8, Parity_EN=0, send 0xA5 -> Data=0xA5, a single Data_valid pulse, no error flags, Busy low afterwards.
- Prescale=16, Parity_EN=1, Parity_type=1, send 0x3C with parity bit 1 -> Data_valid pulses and Data=0x3C. Repeat with the parity bit forced to 0 -> Parity_error pulse, no Data_valid, Data stays 0x3C.
- Prescale=32, send 0x0F with stop bit 0 -> Stop_error pulse, no Data_valid, Data unchanged.
- Low glitch of 3 CLK on Rx_in with Prescale=16 -> return to IDLE, no flags; a following valid 0x55 frame is received correctly.
- Back-to-back frames 0x01, 0xFF with no idle gap, Prescale=8 -> two Data_valid pulses with Data 0x01 then 0xFF.
- Reset=0 for one cycle mid-DATA of frame 0x81 -> all outputs 0; the next frame 0x42 is received correctly.
- Additionally, under RX_MAJORITY_EN: a 1-cycle inverted spike at P/2 of a data bit is rejected and the word is received correctly.
